// File: rtl/fp_pool_stream_if.sv
// Ready/valid bundle for fp_pool_stream: per-beat lane vectors in, one reduced beat per window out.
// WIDTH and IDXW are derived here so the interface and the reducer always agree on field sizes.
interface fp_pool_stream_if #(
   parameter int EXP    = 8,
   parameter int MANT   = 7,
   parameter int LANES  = 4,
   parameter int WINDOW = 9
);
   localparam int WIDTH = 1 + EXP + MANT;
   localparam int IDXW  = (WINDOW > 1) ? $clog2(WINDOW) : 1;

   logic                             in_valid;
   logic                             in_ready;
   logic                             in_mode;
   logic [LANES-1:0][WIDTH-1:0]      in_data;
   logic                             out_valid;
   logic                             out_ready;
   logic [LANES-1:0][WIDTH-1:0]      out_data;
   logic [LANES-1:0][IDXW-1:0]       out_index;
   logic [LANES-1:0]                 out_nan;

   modport master (
      output in_valid, in_mode, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_index, out_nan
   );

   modport slave (
      input  in_valid, in_mode, in_data, out_ready,
      output in_ready, out_valid, out_data, out_index, out_nan
   );
endinterface

// File: rtl/fp_pool_stream.sv
// Streaming per-lane float max/min pooling over WINDOW beats, reporting winner value, beat index and NaN.
// Ties keep the earliest beat; NaN never beats a number; a single output register gives 1 beat/clock.
module fp_pool_stream #(
   parameter int EXP    = 8,
   parameter int MANT   = 7,
   parameter int LANES  = 4,
   parameter int WINDOW = 9
) (
   input logic             clock,
   input logic             clock_sreset,
   fp_pool_stream_if.slave bus
);
   localparam int WIDTH = 1 + EXP + MANT;
   localparam int IDXW  = (WINDOW > 1) ? $clog2(WINDOW) : 1;

   typedef logic [WIDTH-1:0] elem_t;
   typedef logic [IDXW-1:0]  idx_t;

   localparam elem_t SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};
   localparam idx_t  LAST_IDX = idx_t'(WINDOW - 1);

   function automatic logic is_nan(elem_t x);
      return (&x[WIDTH-2:MANT]) && (|x[MANT-1:0]);
   endfunction

   // Monotonic unsigned key: -0 folds onto +0, negatives invert, positives get the top bit set.
   function automatic elem_t order_key(elem_t x);
      elem_t z;
      z = (x == SIGN_BIT) ? '0 : x;
      return z[WIDTH-1] ? ~z : (z | SIGN_BIT);
   endfunction

   function automatic logic beats(elem_t cand, elem_t acc, logic min_mode);
      if (is_nan(cand)) return 1'b0;
      if (is_nan(acc))  return 1'b1;
      return min_mode ? (order_key(cand) < order_key(acc))
                      : (order_key(cand) > order_key(acc));
   endfunction

   idx_t                count_q, count_d;
   logic                mode_q, mode_d;
   elem_t [LANES-1:0]   acc_q, acc_d;
   idx_t  [LANES-1:0]   idx_q, idx_d;
   logic  [LANES-1:0]   nan_q, nan_d;
   logic                out_valid_q, out_valid_d;
   elem_t [LANES-1:0]   out_data_q, out_data_d;
   idx_t  [LANES-1:0]   out_index_q, out_index_d;
   logic  [LANES-1:0]   out_nan_q, out_nan_d;

   elem_t [LANES-1:0]   win_data;
   idx_t  [LANES-1:0]   win_idx;
   logic  [LANES-1:0]   win_nan;
   logic                accept;
   logic                first;
   logic                last;
   logic                mode_eff;

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign first        = (count_q == '0);
   assign last         = (count_q == LAST_IDX);
   assign mode_eff     = first ? bus.in_mode : mode_q;

   // Running result including the current beat; on the first beat count_q is 0, so idx becomes 0.
   always_comb begin : lane_merge
      for (int l = 0; l < LANES; l++) begin
         if (first || beats(bus.in_data[l], acc_q[l], mode_eff)) begin
            win_data[l] = bus.in_data[l];
            win_idx[l]  = count_q;
         end else begin
            win_data[l] = acc_q[l];
            win_idx[l]  = idx_q[l];
         end
         win_nan[l] = is_nan(bus.in_data[l]) || (!first && nan_q[l]);
      end
   end

   always_comb begin : next_state
      // NOTE: every _d starts at its hold value so no path leaves it unassigned (no latch).
      count_d     = count_q;
      mode_d      = mode_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      nan_d       = nan_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      out_nan_d   = out_nan_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      if (accept) begin
         mode_d = mode_eff;
         if (last) begin
            out_data_d  = win_data;
            out_index_d = win_idx;
            out_nan_d   = win_nan;
            out_valid_d = 1'b1;
            count_d     = '0;
         end else begin
            acc_d   = win_data;
            idx_d   = win_idx;
            nan_d   = win_nan;
            count_d = count_q + idx_t'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (clock_sreset) begin
         // NOTE: accumulators are a few flops per lane, so they are cleared along with the rest.
         count_q     <= '0;
         mode_q      <= 1'b0;
         acc_q       <= '0;
         idx_q       <= '0;
         nan_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_nan_q   <= '0;
      end else begin
         count_q     <= count_d;
         mode_q      <= mode_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         nan_q       <= nan_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         out_nan_q   <= out_nan_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_index = out_index_q;
   assign bus.out_nan   = out_nan_q;
endmodule

// File: tb/tb_fp_pool_stream.sv
// Bench for fp_pool_stream: bf16 LANES=1/WINDOW=4 instance for pooling behaviour,
// LANES=4/WINDOW=1 instance for pass-through; results scoreboarded against a sign/magnitude model.
module tb_fp_pool_stream;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst4;
   logic rst1;
   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;
   bit   rand_ready_en = 1'b0;

   always @(posedge clk) cyc++;

   fp_pool_stream_if #(.EXP(8), .MANT(7), .LANES(1), .WINDOW(4)) bus4 ();
   fp_pool_stream_if #(.EXP(8), .MANT(7), .LANES(4), .WINDOW(1)) bus1 ();

   fp_pool_stream #(.EXP(8), .MANT(7), .LANES(1), .WINDOW(4)) u_dut4 (
      .clock(clk), .clock_sreset(rst4), .bus(bus4)
   );
   fp_pool_stream #(.EXP(8), .MANT(7), .LANES(4), .WINDOW(1)) u_dut1 (
      .clock(clk), .clock_sreset(rst1), .bus(bus1)
   );

   typedef logic [0:3][15:0] beats_t;
   typedef struct packed { logic [15:0] d; logic [1:0] i; logic n; } exp4_t;
   typedef struct packed { logic [3:0][15:0] d; logic [3:0] n; } exp1_t;

   exp4_t q4[$];
   exp1_t q1[$];
   logic [15:0] specials [0:6] = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC0, 16'h0001, 16'h8001};

   function automatic bit tb_is_nan(logic [15:0] x);
      return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
   endfunction

   // Sign/magnitude comparison of two non-NaN bf16 values: 1 if a>b, -1 if a<b, 0 if equal.
   function automatic int fcmp(logic [15:0] a, logic [15:0] b);
      bit az = (a[14:0] == 15'd0);
      bit bz = (b[14:0] == 15'd0);
      bit an = a[15] && !az;
      bit bn = b[15] && !bz;
      if (az && bz) return 0;
      if (an != bn) return an ? -1 : 1;
      if (a[14:0] == b[14:0]) return 0;
      if (an) return (a[14:0] > b[14:0]) ? -1 : 1;
      return (a[14:0] > b[14:0]) ? 1 : -1;
   endfunction

   function automatic exp4_t model4(beats_t b, logic m);
      exp4_t r;
      r.d = b[0];
      r.i = 2'd0;
      r.n = tb_is_nan(b[0]);
      for (int k = 1; k < 4; k++) begin
         r.n = r.n | tb_is_nan(b[k]);
         if (!tb_is_nan(b[k]) &&
             (tb_is_nan(r.d) || (m ? (fcmp(b[k], r.d) < 0) : (fcmp(b[k], r.d) > 0)))) begin
            r.d = b[k];
            r.i = 2'(k);
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] rand_val();
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 6)];
      return 16'($urandom);
   endfunction

   // Scoreboard monitors: a result is consumed on the edge following a negedge with valid & ready.
   exp4_t m4_e, m4_g;
   always @(negedge clk) begin
      if (rst4 === 1'b0 && bus4.out_valid === 1'b1 && bus4.out_ready === 1'b1) begin
         m4_g = '{d: bus4.out_data[0], i: bus4.out_index[0], n: bus4.out_nan[0]};
         n_total++;
         if (q4.size() == 0) begin
            $display("FAIL mon4_unexpected got data=%h idx=%0d nan=%b", m4_g.d, m4_g.i, m4_g.n);
         end else begin
            m4_e = q4.pop_front();
            if (m4_g !== m4_e)
               $display("FAIL mon4_result got data=%h idx=%0d nan=%b want data=%h idx=%0d nan=%b",
                        m4_g.d, m4_g.i, m4_g.n, m4_e.d, m4_e.i, m4_e.n);
            else n_pass++;
         end
      end
   end

   exp1_t m1_e, m1_g;
   always @(negedge clk) begin
      if (rst1 === 1'b0 && bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
         m1_g = '{d: bus1.out_data, n: bus1.out_nan};
         n_total++;
         if (q1.size() == 0) begin
            $display("FAIL mon1_unexpected got data=%h", m1_g.d);
         end else begin
            m1_e = q1.pop_front();
            if (m1_g !== m1_e || bus1.out_index !== 4'b0000)
               $display("FAIL mon1_result got data=%h nan=%b idx=%b want data=%h nan=%b idx=0",
                        m1_g.d, m1_g.n, bus1.out_index, m1_e.d, m1_e.n);
            else n_pass++;
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready_en) begin
         #1;
         bus1.out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic send_beat4(input logic [15:0] d, input logic m);
      bit got = 1'b0;
      int waited = 0;
      bus4.in_valid   = 1'b1;
      bus4.in_data[0] = d;
      bus4.in_mode    = m;
      while (!got && waited < 100) begin
         @(negedge clk);
         got = bus4.in_ready;
         @(posedge clk);
         #1;
         waited++;
      end
      if (!got) begin
         n_total++;
         $display("FAIL beat4_timeout data=%h never accepted within %0d cycles", d, waited);
      end
      bus4.in_valid   = 1'b0;
      bus4.in_data[0] = 16'($urandom);
   endtask

   task automatic send_window(input beats_t b, input logic [0:3] modes, input exp4_t e);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) q4.push_back(e);
         send_beat4(b[k], modes[k]);
      end
   endtask

   task automatic wait_drain4(input string name);
      int w = 0;
      while (q4.size() != 0 && w < 100) begin
         @(posedge clk);
         w++;
      end
      #1;
      n_total++;
      if (q4.size() != 0) $display("FAIL %s_drain got %0d pending want 0", name, q4.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      rst4 = 1'b1;
      rst1 = 1'b1;
      bus4.in_valid = 1'b0; bus4.in_mode = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;
      bus1.in_valid = 1'b0; bus1.in_mode = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if ({bus4.out_valid, bus4.out_data, bus4.out_index, bus4.out_nan, bus4.in_ready} !== {1'b0, 16'h0, 2'd0, 1'b0, 1'b1})
         $display("FAIL reset4 got v=%b d=%h i=%0d n=%b rdy=%b want v=0 d=0 i=0 n=0 rdy=1",
                  bus4.out_valid, bus4.out_data, bus4.out_index, bus4.out_nan, bus4.in_ready);
      else n_pass++;
      n_total++;
      if ({bus1.out_valid, bus1.out_data, bus1.out_index, bus1.out_nan, bus1.in_ready} !== {1'b0, 64'h0, 4'd0, 4'd0, 1'b1})
         $display("FAIL reset1 got v=%b d=%h rdy=%b want v=0 d=0 rdy=1", bus1.out_valid, bus1.out_data, bus1.in_ready);
      else n_pass++;
      rst4 = 1'b0;
      rst1 = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_max_min();
      beats_t b = '{16'h3F80, 16'hC040, 16'h4000, 16'h3F80};
      send_window(b, 4'b0000, '{16'h4000, 2'd2, 1'b0});
      send_window(b, 4'b1100, '{16'hC040, 2'd1, 1'b0});
      send_window(b, 4'b0011, '{16'h4000, 2'd2, 1'b0});
      wait_drain4("max_min");
   endtask

   task automatic test_ties_nan();
      send_window('{16'h8000, 16'h0000, 16'h8000, 16'hFF80}, 4'b0000, '{16'h8000, 2'd0, 1'b0});
      send_window('{16'h0000, 16'h8000, 16'h0000, 16'h7F80}, 4'b1111, '{16'h0000, 2'd0, 1'b0});
      send_window('{16'h7FC0, 16'hFF80, 16'h7FC0, 16'hFF80}, 4'b0000, '{16'hFF80, 2'd1, 1'b1});
      send_window('{16'h7FC0, 16'h7FC0, 16'h7FC0, 16'h7FC0}, 4'b0000, '{16'h7FC0, 2'd0, 1'b1});
      send_window('{16'h0001, 16'h7F80, 16'hFF80, 16'h0080}, 4'b0000, '{16'h7F80, 2'd1, 1'b0});
      send_window('{16'h0001, 16'h7F80, 16'hFF80, 16'h0080}, 4'b1000, '{16'hFF80, 2'd2, 1'b0});
      send_window('{16'h8001, 16'h8002, 16'h8000, 16'hFF80}, 4'b0000, '{16'h8000, 2'd2, 1'b0});
      wait_drain4("ties_nan");
   endtask

   task automatic test_random();
      beats_t b;
      logic [0:3] modes;
      for (int w = 0; w < 20; w++) begin
         for (int k = 0; k < 4; k++) b[k] = rand_val();
         modes = 4'($urandom);
         send_window(b, modes, model4(b, modes[0]));
      end
      wait_drain4("random");
   endtask

   task automatic test_backpressure();
      logic [15:0] hold;
      bus4.out_ready = 1'b0;
      send_window('{16'h3F80, 16'hC040, 16'h4000, 16'h3F80}, 4'b0000, '{16'h4000, 2'd2, 1'b0});
      n_total++;
      if (bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b0)
         $display("FAIL bp_stall got v=%b rdy=%b want v=1 rdy=0", bus4.out_valid, bus4.in_ready);
      else n_pass++;
      hold = bus4.out_data[0];
      fork
         send_window('{16'hC000, 16'h4040, 16'h0000, 16'h4040}, 4'b0000, '{16'h4040, 2'd1, 1'b0});
         begin
            for (int c = 0; c < 4; c++) begin
               @(posedge clk);
               #1;
               n_total++;
               if (bus4.out_valid !== 1'b1 || bus4.out_data[0] !== hold)
                  $display("FAIL bp_hold got v=%b d=%h want v=1 d=%h", bus4.out_valid, bus4.out_data[0], hold);
               else n_pass++;
            end
            bus4.out_ready = 1'b1;
         end
      join
      wait_drain4("backpressure");
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if (bus4.out_valid !== 1'b0) $display("FAIL bp_clear got v=%b want 0", bus4.out_valid);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      beats_t b;
      int start;
      bus4.out_ready = 1'b1;
      start = cyc;
      for (int w = 0; w < 3; w++) begin
         for (int k = 0; k < 4; k++) b[k] = rand_val();
         send_window(b, 4'b0000, model4(b, 1'b0));
      end
      n_total++;
      if (cyc - start !== 12) $display("FAIL b2b_cycles got %0d want 12", cyc - start);
      else n_pass++;
      wait_drain4("back_to_back");
   endtask

   task automatic test_sreset_mid_window();
      bus4.out_ready = 1'b1;
      send_window('{16'h3F80, 16'hC040, 16'h4000, 16'h3F80}, 4'b0000, '{16'h4000, 2'd2, 1'b0});
      send_beat4(16'h7F00, 1'b0);
      send_beat4(16'h7F00, 1'b0);
      wait_drain4("sreset_pre");
      rst4 = 1'b1;
      @(posedge clk);
      #1;
      n_total++;
      if ({bus4.out_valid, bus4.out_data, bus4.out_index, bus4.out_nan} !== {1'b0, 16'h0, 2'd0, 1'b0})
         $display("FAIL sreset_outputs got v=%b d=%h i=%0d n=%b want all 0",
                  bus4.out_valid, bus4.out_data, bus4.out_index, bus4.out_nan);
      else n_pass++;
      rst4 = 1'b0;
      send_window('{16'h3F80, 16'h4000, 16'h4040, 16'h4080}, 4'b0000, '{16'h4080, 2'd3, 1'b0});
      send_window('{16'h4080, 16'h4040, 16'h4000, 16'h3F80}, 4'b1111, '{16'h3F80, 2'd3, 1'b0});
      wait_drain4("sreset_post");
   endtask

   task automatic test_window1();
      exp1_t e;
      bit got;
      int waited;
      rand_ready_en = 1'b1;
      for (int t = 0; t < 40; t++) begin
         repeat ($urandom_range(0, 1)) @(posedge clk);
         #1;
         for (int l = 0; l < 4; l++) begin
            e.d[l] = rand_val();
            e.n[l] = tb_is_nan(e.d[l]);
         end
         q1.push_back(e);
         bus1.in_valid = 1'b1;
         bus1.in_data  = e.d;
         bus1.in_mode  = 1'($urandom_range(0, 1));
         got = 1'b0;
         waited = 0;
         while (!got && waited < 100) begin
            @(negedge clk);
            got = bus1.in_ready;
            @(posedge clk);
            #1;
            waited++;
         end
         n_total++;
         if (!got || bus1.out_valid !== 1'b1 || bus1.out_data !== e.d || bus1.out_index !== 4'd0)
            $display("FAIL w1_latency got acc=%b v=%b d=%h i=%b want acc=1 v=1 d=%h i=0",
                     got, bus1.out_valid, bus1.out_data, bus1.out_index, e.d);
         else n_pass++;
         bus1.in_valid = 1'b0;
         bus1.in_data  = {4{16'($urandom)}};
      end
      rand_ready_en = 1'b0;
      @(posedge clk);
      #2;
      bus1.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (q1.size() != 0) $display("FAIL w1_drain got %0d pending want 0", q1.size());
      else n_pass++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_max_min();
      test_ties_nan();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_sreset_mid_window();
      test_window1();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
